// File: rtl/simple_bram_ctrl_core.sv
// simple_bram_ctrl_core
//   Single-port BRAM sequencer. On i_run it writes N words (data = address)
//   to addresses 0..N-1, then reads the same N words back in order and
//   streams them out with a valid strobe. Drives port A of a single-clock
//   BRAM with one cycle of read latency.
//
// Ports
//   clk         clock, rising edge
//   reset_n     asynchronous reset, active HIGH (legacy name)
//   i_run       start pulse, sampled only in IDLE
//   i_num_cnt   word count N, latched when i_run is accepted
//   o_idle/o_write/o_read/o_done   state decodes (o_done is a one-cycle pulse)
//   addr0/ce0/we0/d0               BRAM port A request
//   q0                             BRAM port A read data (1 cycle after request)
//   o_valid/o_mem_data             read-back stream
module simple_bram_ctrl_core #(
   parameter int DWIDTH   = 16,
   parameter int AWIDTH   = 7,
   parameter int MEM_SIZE = 128
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_run,
   input  logic [AWIDTH-1:0] i_num_cnt,
   output logic              o_idle,
   output logic              o_write,
   output logic              o_read,
   output logic              o_done,
   output logic [AWIDTH-1:0] addr0,
   output logic              ce0,
   output logic              we0,
   input  logic [DWIDTH-1:0] q0,
   output logic [DWIDTH-1:0] d0,
   output logic              o_valid,
   output logic [DWIDTH-1:0] o_mem_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [AWIDTH-1:0] ONE       = AWIDTH'(1);
   // Last addressable word; acts as a hard stop so the counter never wraps.
   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] cnt, cnt_nxt;
   logic [AWIDTH-1:0] num, num_nxt;
   logic              last;

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         num     <= '0;
         o_valid <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         num     <= num_nxt;
         // Read data returns one cycle after the request, so valid is
         // simply the READ state delayed by one register.
         o_valid <= (state == READ);
      end
   end

   assign last = (cnt == (num - ONE)) || (cnt == LAST_ADDR);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      num_nxt   = num;
      unique case (state)
         IDLE: begin
            if (i_run) begin
               num_nxt   = i_num_cnt;
               cnt_nxt   = '0;
               state_nxt = (i_num_cnt != '0) ? WRITE : DONE;
            end
         end
         WRITE: begin
            if (last) begin
               cnt_nxt   = '0;
               state_nxt = READ;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         READ: begin
            if (last) begin
               cnt_nxt   = '0;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      o_idle  = (state == IDLE);
      o_write = (state == WRITE);
      o_read  = (state == READ);
      o_done  = (state == DONE);
      ce0     = o_write || o_read;
      we0     = o_write;
      addr0   = ce0 ? cnt : '0;
      d0      = o_write ? DWIDTH'(cnt) : '0;
   end

   assign o_mem_data = q0;

endmodule

// File: tb/tb_simple_bram_ctrl_core.sv
module tb_simple_bram_ctrl_core;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_run;
   logic [6:0]  i_num_cnt;
   logic        o_idle, o_write, o_read, o_done;
   logic [6:0]  addr0;
   logic        ce0, we0;
   logic [15:0] q0, d0;
   logic        o_valid;
   logic [15:0] o_mem_data;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   simple_bram_ctrl_core #(.DWIDTH(16), .AWIDTH(7), .MEM_SIZE(128)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_run      (i_run),
      .i_num_cnt  (i_num_cnt),
      .o_idle     (o_idle),
      .o_write    (o_write),
      .o_read     (o_read),
      .o_done     (o_done),
      .addr0      (addr0),
      .ce0        (ce0),
      .we0        (we0),
      .q0         (q0),
      .d0         (d0),
      .o_valid    (o_valid),
      .o_mem_data (o_mem_data)
   );

   // BRAM port A model: synchronous write, one-cycle registered read.
   // scrub overwrites every word with a marker so stale data cannot pass.
   logic [15:0] mem [0:127];
   logic        scrub = 1'b0;
   always @(posedge clk) begin
      if (scrub) begin
         for (int i = 0; i < 128; i++) mem[i] <= 16'hBEEF;
      end else if (ce0) begin
         if (we0) mem[addr0] <= d0;
         else     q0 <= mem[addr0];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_scrub();
      scrub = 1'b1;
      step();
      scrub = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      logic [6:0] st;
      st = {o_idle, o_write, o_read, o_done, ce0, we0, o_valid};
      total++;
      if (st !== 7'b1000000 || addr0 !== 7'd0 || d0 !== 16'd0) begin
         $display("FAIL %s: status=%b addr0=%0d d0=%0d required status=1000000 addr0=0 d0=0",
                  name, st, addr0, d0);
      end else begin
         passed++;
      end
   endtask

   // Accept a run of n words and check every cycle through the return to IDLE.
   // pulse_at>0 fires a second i_run (N=5) in that cycle, which must be ignored.
   task automatic run_and_check(input int n, input int pulse_at, input string name);
      int         cyc;
      logic [6:0] exp_st, st, ea;
      logic [15:0] ed, ev;
      bit wr, rd;
      do_scrub();
      i_num_cnt = 7'(n);
      i_run     = 1'b1;
      step();
      i_run     = 1'b0;
      i_num_cnt = 7'd3;
      for (cyc = 1; cyc <= 2 * n + 2; cyc++) begin
         wr = (cyc >= 1) && (cyc <= n);
         rd = (cyc >= n + 1) && (cyc <= 2 * n);
         exp_st = {cyc == 2 * n + 2, wr, rd, cyc == 2 * n + 1, wr || rd, wr,
                   (cyc >= n + 2) && (cyc <= 2 * n + 1)};
         ea = wr ? 7'(cyc - 1) : (rd ? 7'(cyc - n - 1) : 7'd0);
         ed = 16'(cyc - 1);
         ev = 16'(cyc - n - 2);
         st = {o_idle, o_write, o_read, o_done, ce0, we0, o_valid};
         total++;
         if (st !== exp_st) $display("FAIL %s status cyc %0d: got %b required %b", name, cyc, st, exp_st);
         else passed++;
         total++;
         if (addr0 !== ea) $display("FAIL %s addr0 cyc %0d: got %0d required %0d", name, cyc, addr0, ea);
         else passed++;
         if (wr) begin
            total++;
            if (d0 !== ed) $display("FAIL %s d0 cyc %0d: got %0d required %0d", name, cyc, d0, ed);
            else passed++;
         end else if (!rd) begin
            total++;
            if (d0 !== 16'd0) $display("FAIL %s d0 idle cyc %0d: got %0d required 0", name, cyc, d0);
            else passed++;
         end
         if (exp_st[0]) begin
            total++;
            if (o_mem_data !== ev)
               $display("FAIL %s o_mem_data cyc %0d: got %0d required %0d", name, cyc, o_mem_data, ev);
            else passed++;
         end
         if (cyc == pulse_at) begin
            i_num_cnt = 7'd5;
            i_run     = 1'b1;
         end
         step();
         i_run = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b1;
      i_run     = 1'b0;
      i_num_cnt = 7'd0;
      step();
      step();
      check_reset_outputs("reset_state");
      reset_n = 1'b0;
      step();
      check_reset_outputs("after_release");
   endtask

   task automatic test_async_reset();
      do_scrub();
      i_num_cnt = 7'd10;
      i_run     = 1'b1;
      step();
      i_run = 1'b0;
      step();
      step();
      total++;
      if (o_write !== 1'b1 || addr0 !== 7'd2)
         $display("FAIL async_pre: o_write=%b addr0=%0d required 1 and 2", o_write, addr0);
      else passed++;
      #1 reset_n = 1'b1;
      #1 check_reset_outputs("async_reset_mid_write");
      step();
      reset_n = 1'b0;
      step();
      check_reset_outputs("async_after_release");
   endtask

   initial begin
      test_reset();
      run_and_check(100, 0, "n100");
      run_and_check(1, 0, "n1");
      run_and_check(0, 0, "n0");
      run_and_check(127, 0, "n127");
      run_and_check(10, 3, "back_to_back_ignore");
      test_async_reset();
      run_and_check(4, 0, "after_reset_run");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
